// File: rtl/vend_sequencer_if.sv
// Coin-sensor, dispense and change-ejector signals of the vending sequencer,
// bundled so the controller and its environment share one port.
interface vend_sequencer_if;
    logic       coin1;
    logic       coin2;
    logic       cancel;
    logic       vend_req;
    logic       vend_ack;
    logic       chg_req;
    logic       chg_ack;
    logic [3:0] credit;
    logic [3:0] products;
    logic       busy;
    logic       coin_rej;

    modport slave (
        input  coin1, coin2, cancel, vend_ack, chg_ack,
        output vend_req, chg_req, credit, products, busy, coin_rej
    );

    modport master (
        output coin1, coin2, cancel, vend_ack, chg_ack,
        input  vend_req, chg_req, credit, products, busy, coin_rej
    );
endinterface

// File: rtl/vend_sequencer.sv
// Vending-machine sequencer: synchronises coin/cancel sensors, accumulates
// credit, requests a dispense, then returns change one coin at a time.
module vend_sequencer #(
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    vend_sequencer_if.slave   bus
);
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_COLLECT = 2'd1;
    localparam logic [1:0]  ST_VEND    = 2'd2;
    localparam logic [1:0]  ST_CHANGE  = 2'd3;
    localparam logic [3:0]  PRICE_C    = 4'(PRICE);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    // bit 0 = coin1, bit 1 = coin2, bit 2 = cancel
    logic [2:0]  meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
    logic [1:0]  warm_q, warm_d;
    logic [2:0]  evt_s;

    logic [1:0]  state_q, state_d;
    logic [3:0]  credit_q, credit_d, products_q, products_d;
    logic [15:0] timer_q, timer_d;
    logic        vend_req_q, vend_req_d, chg_req_q, chg_req_d;
    logic        busy_q, busy_d, coin_rej_q, coin_rej_d;
    logic [3:0]  coin_add_s, credit_sum_s;
    logic        coin_evt_s, cancel_evt_s;

    // Synchroniser and edge detect; for two edges after reset the edge flop is
    // forced high so a pin held through reset must fall before it can count.
    always_comb begin
        meta_d = {bus.cancel, bus.coin2, bus.coin1};
        sync_d = meta_q;
        if (warm_q != 2'd2) begin
            prev_d = 3'b111;
            warm_d = warm_q + 2'd1;
        end else begin
            prev_d = sync_q;
            warm_d = warm_q;
        end
        evt_s = sync_q & ~prev_q;
    end

    // Sequencer next-state logic
    always_comb begin
        coin_add_s   = {3'd0, evt_s[0]} + {2'd0, evt_s[1], 1'b0};
        coin_evt_s   = evt_s[0] | evt_s[1];
        cancel_evt_s = evt_s[2];
        credit_sum_s = credit_q + coin_add_s;
        state_d      = state_q;
        credit_d     = credit_q;
        products_d   = products_q;
        timer_d      = timer_q;
        chg_req_d    = chg_req_q;
        coin_rej_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (coin_evt_s) begin
                    // coin is credited before a same-cycle cancel is considered
                    credit_d = credit_sum_s;
                    timer_d  = 16'd0;
                    if (credit_sum_s >= PRICE_C) begin
                        state_d = ST_VEND;
                    end else if (cancel_evt_s && (state_q == ST_COLLECT)) begin
                        state_d = ST_CHANGE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (state_q == ST_COLLECT) begin
                    if (cancel_evt_s || (timer_q == TMO_LAST)) begin
                        state_d = ST_CHANGE;
                        timer_d = 16'd0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end else begin
                    timer_d = 16'd0;
                end
            end
            ST_VEND: begin
                coin_rej_d = coin_evt_s;
                if (bus.vend_ack) begin
                    credit_d   = credit_q - PRICE_C;
                    products_d = products_q + 4'd1;
                    state_d    = (credit_q > PRICE_C) ? ST_CHANGE : ST_IDLE;
                end else begin
                    state_d = ST_VEND;
                end
            end
            ST_CHANGE: begin
                coin_rej_d = coin_evt_s;
                if (chg_req_q) begin
                    if (bus.chg_ack) begin
                        chg_req_d = 1'b0;
                        credit_d  = credit_q - 4'd1;
                    end else begin
                        chg_req_d = 1'b1;
                    end
                end else if (!bus.chg_ack) begin
                    // request only once the previous acknowledge has dropped
                    if (credit_q != 4'd0) begin
                        chg_req_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    chg_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                chg_req_d = 1'b0;
            end
        endcase
        vend_req_d = (state_d == ST_VEND);
        busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 3'b000;
            sync_q     <= 3'b000;
            prev_q     <= 3'b000;
            warm_q     <= 2'd0;
            state_q    <= ST_IDLE;
            credit_q   <= 4'd0;
            products_q <= 4'd0;
            timer_q    <= 16'd0;
            vend_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            warm_q     <= warm_d;
            state_q    <= state_d;
            credit_q   <= credit_d;
            products_q <= products_d;
            timer_q    <= timer_d;
            vend_req_q <= vend_req_d;
            chg_req_q  <= chg_req_d;
            busy_q     <= busy_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign bus.vend_req = vend_req_q;
    assign bus.chg_req  = chg_req_q;
    assign bus.credit   = credit_q;
    assign bus.products = products_q;
    assign bus.busy     = busy_q;
    assign bus.coin_rej = coin_rej_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// Randomised bench for vend_sequencer: a transaction-level credit/product model
// predicts credit, product count, dispense and refund behaviour.
module tb_vend_sequencer;
    localparam int PRICE   = 3;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst_n;
    vend_sequencer_if bus();

    vend_sequencer #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int m_credit   = 0;
    int m_products = 0;
    int n_vend     = 0;
    int rej_cnt    = 0;

    // count coin_rej cycles
    always @(negedge clk) if (bus.coin_rej === 1'b1) rej_cnt++;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pin pulse: two cycles high, two low; the event's effect lands inside it.
    task automatic pulse(input int c1, input int c2, input int cn);
        bus.coin1  = c1[0];
        bus.coin2  = c2[0];
        bus.cancel = cn[0];
        tick(2);
        bus.coin1  = 1'b0;
        bus.coin2  = 1'b0;
        bus.cancel = 1'b0;
        tick(2);
    endtask

    task automatic insert(input int c1, input int c2, input int cn);
        pulse(c1, c2, cn);
        m_credit += c1 + 2 * c2;
        chk_eq("credit_after_coin", int'(bus.credit), m_credit);
        chk_eq("vend_req_after_coin", int'(bus.vend_req), (m_credit >= PRICE) ? 1 : 0);
    endtask

    task automatic reject_coin();
        int r0;
        r0 = rej_cnt;
        pulse(1, 0, 0);
        chk_eq("coin_rej_one_cycle", rej_cnt - r0, 1);
        chk_eq("credit_kept_on_rej", int'(bus.credit), m_credit);
    endtask

    task automatic do_change();
        int n;
        int w;
        n = m_credit;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (bus.chg_req !== 1'b1 && w < 40) begin
                tick(1);
                w++;
            end
            if (bus.chg_req !== 1'b1) begin
                chk_eq("chg_req_wait", 0, 1);
                m_credit = 0;
                return;
            end
            chk_eq("busy_in_change", int'(bus.busy), 1);
            bus.chg_ack = 1'b1;
            tick(1);
            m_credit--;
            chk_eq("credit_after_chg", int'(bus.credit), m_credit);
            chk_eq("chg_req_drop", int'(bus.chg_req), 0);
            tick(2);
            chk_eq("chg_req_while_ack", int'(bus.chg_req), 0);
            bus.chg_ack = 1'b0;
            tick(1);
        end
        tick(3);
        chk_eq("chg_done_req", int'(bus.chg_req), 0);
        chk_eq("chg_done_busy", int'(bus.busy), 0);
        chk_eq("chg_done_credit", int'(bus.credit), 0);
        m_credit = 0;
    endtask

    task automatic do_vend(input int rej);
        chk_eq("vend_req_high", int'(bus.vend_req), 1);
        chk_eq("busy_in_vend", int'(bus.busy), 1);
        if (rej != 0) reject_coin();
        bus.vend_ack = 1'b1;
        tick(1);
        bus.vend_ack = 1'b0;
        m_credit  -= PRICE;
        m_products = (m_products + 1) % 16;
        n_vend++;
        chk_eq("products", int'(bus.products), m_products);
        chk_eq("credit_after_vend", int'(bus.credit), m_credit);
        chk_eq("vend_req_low", int'(bus.vend_req), 0);
        if (m_credit > 0) begin
            do_change();
        end else begin
            tick(2);
            chk_eq("no_change_req", int'(bus.chg_req), 0);
            chk_eq("idle_after_vend", int'(bus.busy), 0);
        end
    endtask

    task automatic run_txn();
        int sel;
        int prev;
        bit done;
        done = 1'b0;
        while (!done) begin
            if (m_credit > 0 && $urandom_range(0, 7) == 0) begin
                tick(15);
                chk_eq("no_early_refund", int'(bus.chg_req), 0);
                do_change();
                done = 1'b1;
            end else begin
                sel = $urandom_range(0, 3);
                if (sel == 0 && m_credit == 0) sel = 1;
                prev = m_credit;
                if (sel == 0) insert(0, 0, 1);
                else insert(sel & 1, (sel >> 1) & 1, ($urandom_range(0, 5) == 0) ? 1 : 0);
                if (m_credit >= PRICE) begin
                    do_vend(($urandom_range(0, 3) == 0) ? 1 : 0);
                    done = 1'b1;
                end else if (sel == 0 || (bus.busy === 1'b1 && prev > 0)) begin
                    // cancel in COLLECT (alone or alongside a coin) refunds
                    chk_eq("cancel_to_change", int'(bus.busy), 1);
                    do_change();
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bus.coin1 = 1'b0; bus.coin2 = 1'b0; bus.cancel = 1'b0;
        bus.vend_ack = 1'b0; bus.chg_ack = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_credit", int'(bus.credit), 0);
        chk_eq("rst_products", int'(bus.products), 0);
        chk_eq("rst_vend_req", int'(bus.vend_req), 0);
        chk_eq("rst_chg_req", int'(bus.chg_req), 0);
        chk_eq("rst_busy", int'(bus.busy), 0);
        chk_eq("rst_coin_rej", int'(bus.coin_rej), 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // coin1 then coin2 reaches price exactly
        insert(1, 0, 0);
        insert(0, 1, 0);
        do_vend(0);
        // simultaneous coins add 3 in one edge
        insert(1, 1, 0);
        do_vend(0);
        // overpay by one, one coin of change
        insert(0, 1, 0);
        insert(0, 1, 0);
        do_vend(1);
        // timeout refund of two units
        insert(0, 1, 0);
        tick(15);
        chk_eq("timeout_not_yet", int'(bus.busy), 0);
        do_change();
        chk_eq("timeout_products", int'(bus.products), m_products);

        for (int t = 0; t < 200 && n_vend < 20; t++) run_txn();
        chk_eq("products_wrapped", int'(bus.products), n_vend % 16);

        // pin held high across reset must not count
        bus.coin2 = 1'b1;
        rst_n = 1'b0;
        m_credit = 0;
        m_products = 0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk_eq("held_pin_no_event", int'(bus.credit), 0);
        bus.coin2 = 1'b0;
        tick(4);
        chk_eq("held_pin_release", int'(bus.credit), 0);
        insert(1, 0, 0);
        insert(0, 0, 1);
        do_change();

        // reset in the middle of change return
        insert(0, 1, 0);
        insert(0, 1, 0);
        bus.vend_ack = 1'b1;
        tick(1);
        bus.vend_ack = 1'b0;
        for (int w = 0; w < 10 && bus.chg_req !== 1'b1; w++) tick(1);
        chk_eq("mid_change_req", int'(bus.chg_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("abort_chg_req", int'(bus.chg_req), 0);
        chk_eq("abort_credit", int'(bus.credit), 0);
        chk_eq("abort_products", int'(bus.products), 0);
        chk_eq("abort_busy", int'(bus.busy), 0);
        chk_eq("abort_vend_req", int'(bus.vend_req), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 The block SHALL have parameter PRICE, default 3, product price in coin units (legal 1..12).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, idle clock cycles in COLLECT before automatic refund.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port coin1  input  1  asynchronous level from the 1-unit coin sensor.
REQ-006 The block SHALL have port coin2  input  1  asynchronous level from the 2-unit coin sensor.
REQ-007 The block SHALL have port cancel  input  1  asynchronous level from the cancel button.
REQ-008 The block SHALL have port vend_req  output  1  dispense request to the product mechanism.
REQ-009 The block SHALL have port vend_ack  input  1  dispense acknowledge, synchronous to clk.
REQ-010 The block SHALL have port chg_req  output  1  request to eject one 1-unit coin.
REQ-011 The block SHALL have port chg_ack  input  1  change acknowledge, synchronous to clk.
REQ-012 The block SHALL have port credit  output  4  current credit in coin units.
REQ-013 The block SHALL have port products  output  4  products dispensed since reset, modulo 16.
REQ-014 The block SHALL have port busy  output  1  high in VEND or CHANGE.
REQ-015 The block SHALL have port coin_rej  output  1  one-cycle pulse when a coin event arrives in VEND or CHANGE.

Function
REQ-016 coin1, coin2 and cancel SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector, giving one-cycle event pulses.
REQ-017 A pin first sampled high at edge k SHALL produce its event in the cycle after edge k+1, with its effect registered at edge k+2.
REQ-018 The FSM SHALL have states IDLE, COLLECT, VEND and CHANGE, and SHALL reset to IDLE.
REQ-019 In IDLE or COLLECT, the coin1 event SHALL add 1 and the coin2 event SHALL add 2; simultaneous events SHALL add 3 in one edge.
REQ-020 After a coin update, the next state SHALL be COLLECT if 0 < credit < PRICE, or VEND if credit >= PRICE, taking effect at the same edge as the credit update.
REQ-021 vend_req SHALL be high exactly while in VEND.
REQ-022 At the first edge with vend_ack=1 in VEND:
- credit SHALL be reduced by PRICE;
- products SHALL increment, wrapping 15 -> 0;
- the state SHALL become CHANGE if the remaining credit > 0, else IDLE.
REQ-023 CHANGE SHALL use a 4-phase handshake:
- raise chg_req;
- wait for chg_ack=1, then drop chg_req and decrement credit by 1 at that edge;
- wait for chg_ack=0;
- re-raise chg_req only if credit > 0, else go to IDLE.
REQ-024 chg_req SHALL never be high while chg_ack is still high from the previous transfer.
REQ-025 In COLLECT, a 16-bit timer SHALL clear on every accepted coin and increment otherwise; on reaching TIMEOUT-1 the state SHALL go to CHANGE (full refund).
REQ-026 A cancel event in COLLECT SHALL cause CHANGE at the next edge; a cancel event in IDLE, VEND or CHANGE SHALL be ignored.
REQ-027 Coin events in VEND or CHANGE SHALL NOT alter credit and SHALL pulse coin_rej for one cycle.
REQ-028 A coin event and a cancel event in the same COLLECT cycle: the coin SHALL be credited first, then the normal credit >= PRICE check applies; cancel SHALL win only if credit stays below PRICE.
REQ-029 Credit SHALL never exceed PRICE+2 and never go below 0; vend_ack in non-VEND states and chg_ack in non-CHANGE states SHALL be ignored.

Reset
REQ-030 On rst_n low, the block SHALL immediately (asynchronously) set state=IDLE, credit=0, products=0, timer=0, vend_req=0, chg_req=0, coin_rej=0, busy=0, and clear synchronizer and edge flops.
REQ-031 A reset during VEND or CHANGE SHALL abort the transaction with no product counted and no residual request.
REQ-032 After rst_n rises, a pin already held high SHALL NOT generate an event until it falls and rises again.

Verification
REQ-033 PRICE=3: coin1, coin2 -> credit 1 then 3, vend_req high; vend_ack -> products=1, credit=0, IDLE, no chg_req.
REQ-034 coin2, coin2 -> credit 4, vend; ack -> credit 1, one chg_req/chg_ack cycle -> credit 0, IDLE.
REQ-035 coin1 and coin2 in the same cycle from IDLE -> credit 3 in one edge, VEND.
REQ-036 TIMEOUT=20: coin2 then no activity -> CHANGE after 20 cycles; two change handshakes, credit 0, products unchanged.
REQ-037 In VEND, coin1 pulse -> coin_rej one cycle, credit unchanged; rst_n low mid-CHANGE -> chg_req low immediately, all outputs 0.
REQ-038 17 complete vends -> products wraps to 1.
